// File: rtl/rr_select_arbiter_if.sv
// rr_select_arbiter_if: request/grant bundle between the arbiter, its sources and the N:1 selector
interface rr_select_arbiter_if #(
    parameter int N = 9,
    parameter int M = 4
);
    logic [N-1:0] req;
    logic         lock;
    logic         ready;
    logic [M-1:0] sel;
    logic         sel_valid;
    logic [N-1:0] grant;
    modport master (input req, input lock, input ready, output sel, output sel_valid, output grant);
    modport slave (output req, output lock, output ready, input sel, input sel_valid, input grant);
endinterface

// File: rtl/rr_select_arbiter.sv
// rr_select_arbiter: round-robin arbiter producing the select code and valid strobe for an N:1 selector
module rr_select_arbiter #(
    parameter int N = 9,
    parameter int M = 4
) (
    input logic                 clk,
    input logic                 rst,
    rr_select_arbiter_if.master bus
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t       state_q, state_d;
    logic [M-1:0] sel_q, sel_d, last_q, last_d, base;
    logic [N-1:0] grant_q, grant_d, win_oh;
    logic         xfer;
    int           win, idx;
    // Round-robin search starting just past the most recently served source, counting one served at this edge
    always_comb begin
        xfer = state_q == GRANT && bus.ready;
        base = xfer ? sel_q : last_q;
        win = 0;
        idx = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(base) + 1 + k) % N;
            if (bus.req[idx]) win = idx;
        end
        win_oh = '0;
        win_oh[win] = 1'b1;
    end
    // Capture a winner from IDLE, freeze while not ready, and on a transfer hold (lock), advance or release
    always_comb begin
        state_d = state_q;
        sel_d = sel_q;
        grant_d = grant_q;
        last_d = last_q;
        if (state_q == IDLE) begin
            if (|bus.req) begin
                state_d = GRANT;
                sel_d = M'(win);
                grant_d = win_oh;
            end
        end else if (xfer) begin
            last_d = sel_q;
            if (!bus.lock) begin
                if (|bus.req) begin
                    sel_d = M'(win);
                    grant_d = win_oh;
                end else begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
        end
    end
    // Registered state and outputs; reset points last at N-1 so the first search starts at index 0
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q <= '0;
            grant_q <= '0;
            last_q <= M'(N - 1);
        end else begin
            state_q <= state_d;
            sel_q <= sel_d;
            grant_q <= grant_d;
            last_q <= last_d;
        end
    end
    assign bus.sel = sel_q;
    assign bus.sel_valid = state_q == GRANT;
    assign bus.grant = grant_q;
endmodule

// File: tb/tb_rr_select_arbiter.sv
// tb_rr_select_arbiter: directed bench with a behavioural round-robin model and per-cycle comparison
module tb_rr_select_arbiter;
    localparam int N = 9;
    logic  clk = 0;
    logic  rst = 1;
    int    tests = 0;
    int    fails = 0;
    bit    armed = 0;
    int    lit_seq = 0;
    int    lit_done = 0;
    int    lit_v, lit_sel, lit_grant;
    string lit_name;
    int    ws [4] = '{8, 0, 2, 8};
    bit    m_valid = 0;
    int    m_sel = 0;
    int    m_last = N - 1;

    rr_select_arbiter_if #(.N(N), .M(4)) bus ();
    rr_select_arbiter #(.N(N), .M(4)) dut (.clk(clk), .rst(rst), .bus(bus.master));

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : corner
        localparam int NN = g == 0 ? 1 : g == 1 ? 8 : 5;
        localparam int MM = g == 0 ? 1 : 3;
        rr_select_arbiter_if #(.N(NN), .M(MM)) cif ();
        rr_select_arbiter #(.N(NN), .M(MM)) u (.clk(clk), .rst(rst), .bus(cif.master));
        int es = 0;
        bit ev = 0;
        assign cif.req = '1;
        assign cif.lock = 1'b0;
        assign cif.ready = 1'b1;
        // all sources always requesting and always ready: sel counts 0,1,..,NN-1,0 from the first grant
        always @(posedge clk) begin
            if (rst) begin
                ev <= 0;
                es <= 0;
            end else if (!ev) begin
                ev <= 1;
                es <= 0;
            end else begin
                es <= (es + 1) % NN;
            end
        end
    end

    function automatic int pick(input logic [N-1:0] r, input int last);
        for (int d = 1; d <= N; d++) if (r[(last + d) % N]) return (last + d) % N;
        return last;
    endfunction

    // reference behaviour of the main arbiter
    always @(posedge clk) begin
        if (rst) begin
            m_valid <= 0;
            m_sel <= 0;
            m_last <= N - 1;
        end else if (!m_valid) begin
            if (bus.req != 0) begin
                m_valid <= 1;
                m_sel <= pick(bus.req, m_last);
            end
        end else if (bus.ready) begin
            m_last <= m_sel;
            if (!bus.lock) begin
                if (bus.req != 0) m_sel <= pick(bus.req, m_sel);
                else m_valid <= 0;
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // single compare process: model, corner instances and pinned literal expectations
    always @(negedge clk) begin
        if (armed) begin
            chk("valid", int'(bus.sel_valid), int'(m_valid));
            chk("sel", int'(bus.sel), m_sel);
            chk("grant", int'(bus.grant), m_valid ? 1 << m_sel : 0);
            chk("sel_range", int'(int'(bus.sel) < N), 1);
            chk("c1_sel", int'(corner[0].cif.sel), corner[0].es);
            chk("c1_grant", int'(corner[0].cif.grant), corner[0].ev ? 1 : 0);
            chk("c8_sel", int'(corner[1].cif.sel), corner[1].es);
            chk("c8_grant", int'(corner[1].cif.grant), corner[1].ev ? 1 << corner[1].es : 0);
            chk("c8_range", int'(int'(corner[1].cif.sel) < 8), 1);
            chk("c5_sel", int'(corner[2].cif.sel), corner[2].es);
            chk("c5_grant", int'(corner[2].cif.grant), corner[2].ev ? 1 << corner[2].es : 0);
            chk("c5_range", int'(int'(corner[2].cif.sel) < 5), 1);
            if (lit_seq != lit_done) begin
                lit_done <= lit_seq;
                chk({lit_name, "_valid"}, int'(bus.sel_valid), lit_v);
                chk({lit_name, "_sel"}, int'(bus.sel), lit_sel);
                chk({lit_name, "_grant"}, int'(bus.grant), lit_grant);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [N-1:0] r, input logic l, input logic rd);
        bus.req = r;
        bus.lock = l;
        bus.ready = rd;
    endtask

    task automatic expect_lit(input string nm, input int v, input int s, input int g);
        lit_name = nm;
        lit_v = v;
        lit_sel = s;
        lit_grant = g;
        lit_seq++;
    endtask

    initial begin
        drive(9'h1FF, 0, 0);
        cyc();
        armed = 1;
        cyc();
        expect_lit("reset", 0, 0, 0);
        rst = 0;
        cyc();
        expect_lit("first", 1, 0, 'h001);
        drive(9'h1FF, 0, 1);
        for (int i = 1; i <= 9; i++) begin
            cyc();
            expect_lit("rotate", 1, i % 9, 1 << (i % 9));
        end
        drive(9'h004, 0, 1);
        cyc();
        expect_lit("to2", 1, 2, 'h004);
        drive(9'h105, 0, 1);
        for (int i = 0; i < 4; i++) begin
            cyc();
            expect_lit("wrap", 1, ws[i], 1 << ws[i]);
        end
        drive(9'h020, 0, 1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            expect_lit("single5", 1, 5, 'h020);
        end
        drive(9'h008, 0, 1);
        cyc();
        expect_lit("grant3", 1, 3, 'h008);
        drive(9'h000, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            expect_lit("hold", 1, 3, 'h008);
        end
        drive(9'h000, 0, 1);
        cyc();
        expect_lit("release", 0, 3, 0);
        cyc();
        expect_lit("idle_ready", 0, 3, 0);
        drive(9'h010, 0, 0);
        cyc();
        expect_lit("grant4", 1, 4, 'h010);
        drive(9'h1FF, 1, 1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            expect_lit("lock", 1, 4, 'h010);
        end
        drive(9'h1FF, 0, 1);
        cyc();
        expect_lit("unlock", 1, 5, 'h020);
        rst = 1;
        cyc();
        expect_lit("rst_mid", 0, 0, 0);
        rst = 0;
        drive(9'h1FF, 0, 0);
        cyc();
        expect_lit("after_rst", 1, 0, 'h001);
        drive(9'h1FF, 0, 1);
        cyc();
        expect_lit("resume1", 1, 1, 'h002);
        cyc();
        expect_lit("resume2", 1, 2, 'h004);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
